bmem_arbiter: RTL and testbench

- Shares the single burst-memory port (bmem) between the instruction-side cacheline adapter (read-only) and the data-side cacheline adapter (read and write-back).
- One transaction in flight at a time; a transaction is one line-aligned burst of BURST_LEN beats.
- Round-robin grant when both sides request; read beats are routed back to the granted requester.
- Sits between the fetch/LSU cache adapters and the top-level bmem pins.

---
 rtl/bmem_arbiter_pkg.sv | 22 ++
 rtl/bmem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_bmem_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bmem_arbiter_pkg.sv
// Shared types for the burst-memory arbiter: FSM states, requester sides and line geometry.
package rv32i_types;

  typedef enum logic [2:0] {
    IDLE,
    I_RD,
    D_RD,
    D_WR,
    WAIT_R
  } bmem_arb_state_t;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } bmem_side_t;

  localparam int BMEM_BURST_LEN = 4;
  localparam int BMEM_BEAT_W    = 64;
  localparam int BMEM_ADDR_W    = 32;
  localparam int LINE_BYTES     = BMEM_BURST_LEN * BMEM_BEAT_W / 8;

endpackage

// File: rtl/bmem_arbiter.sv
// Shares one burst-memory port between the instruction-side (read-only) and data-side
// (read / write-back) cacheline adapters; one line burst in flight, round-robin on contention.
module bmem_arbiter
  import rv32i_types::*;
#(
  parameter int BURST_LEN = BMEM_BURST_LEN,
  parameter int BEAT_W    = BMEM_BEAT_W,
  parameter int ADDR_W    = BMEM_ADDR_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_req_read,
  input  logic [ADDR_W-1:0]           i_req_addr,
  output logic                        i_req_ack,
  input  logic                        i_flush,
  output logic [BEAT_W-1:0]           i_rdata,
  output logic                        i_rvalid,
  output logic [ADDR_W-1:0]           i_raddr,
  input  logic                        d_req_read,
  input  logic                        d_req_write,
  input  logic [ADDR_W-1:0]           d_req_addr,
  input  logic [BURST_LEN*BEAT_W-1:0] d_req_wdata,
  output logic                        d_req_ack,
  output logic [BEAT_W-1:0]           d_rdata,
  output logic                        d_rvalid,
  output logic [ADDR_W-1:0]           d_raddr,
  output logic [ADDR_W-1:0]           bmem_addr,
  output logic                        bmem_read,
  output logic                        bmem_write,
  output logic [BEAT_W-1:0]           bmem_wdata,
  input  logic                        bmem_ready,
  input  logic [ADDR_W-1:0]           bmem_raddr,
  input  logic [BEAT_W-1:0]           bmem_rdata,
  input  logic                        bmem_rvalid
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  bmem_arb_state_t   state_q, state_d;
  bmem_side_t        rr_q, rr_d;
  bmem_side_t        owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              drop_q, drop_d;

  logic              i_ok;
  logic              d_ok;
  bmem_side_t        grant;
  logic              beat_hit;
  logic [BEAT_W-1:0] wbeat [BURST_LEN];

  for (genvar gi = 0; gi < BURST_LEN; gi++) begin : g_wbeat
    assign wbeat[gi] = d_req_wdata[gi*BEAT_W +: BEAT_W];
  end

  // A flushed instruction request is invisible to the picker in that cycle.
  assign i_ok     = i_req_read && !i_flush;
  assign d_ok     = d_req_read || d_req_write;
  assign grant    = (i_ok && d_ok) ? rr_q : (d_ok ? SIDE_D : SIDE_I);
  assign beat_hit = bmem_rvalid && (bmem_raddr == addr_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= SIDE_D;
      owner_q <= SIDE_I;
      addr_q  <= '0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        drop_d = 1'b0;
        if (i_ok || d_ok) begin
          owner_d = grant;
          addr_d  = (grant == SIDE_D) ? d_req_addr : i_req_addr;
          if (i_ok && d_ok) rr_d = (rr_q == SIDE_D) ? SIDE_I : SIDE_D;
          // A write-back wins over an (illegal) concurrent data read.
          if (grant == SIDE_I)  state_d = I_RD;
          else if (d_req_write) state_d = D_WR;
          else                  state_d = D_RD;
        end
      end
      I_RD: begin
        if (i_flush)         state_d = IDLE;
        else if (bmem_ready) state_d = WAIT_R;
      end
      D_RD: begin
        if (bmem_ready) state_d = WAIT_R;
      end
      D_WR: begin
        if (bmem_ready) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      WAIT_R: begin
        if (owner_q == SIDE_I && i_flush) drop_d = 1'b1;
        // Dropped beats still count so the burst drains before the port is reused.
        if (beat_hit) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            drop_d  = 1'b0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    i_req_ack  = 1'b0;
    d_req_ack  = 1'b0;
    i_rvalid   = 1'b0;
    i_rdata    = '0;
    i_raddr    = '0;
    d_rvalid   = 1'b0;
    d_rdata    = '0;
    d_raddr    = '0;
    bmem_addr  = '0;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_wdata = '0;
    case (state_q)
      I_RD: begin
        bmem_read = !i_flush;
        bmem_addr = addr_q;
        i_req_ack = bmem_ready && !i_flush;
      end
      D_RD: begin
        bmem_read = 1'b1;
        bmem_addr = addr_q;
        d_req_ack = bmem_ready;
      end
      D_WR: begin
        bmem_write = 1'b1;
        bmem_addr  = addr_q;
        bmem_wdata = wbeat[cnt_q];
        d_req_ack  = bmem_ready && (cnt_q == LAST_BEAT);
      end
      WAIT_R: begin
        if (beat_hit) begin
          if (owner_q == SIDE_I) begin
            if (!drop_q && !i_flush) begin
              i_rvalid = 1'b1;
              i_rdata  = bmem_rdata;
              i_raddr  = bmem_raddr;
            end
          end else begin
            d_rvalid = 1'b1;
            d_rdata  = bmem_rdata;
            d_raddr  = bmem_raddr;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bmem_arbiter.sv
// Scenario bench for bmem_arbiter: read beats and write beats are checked against queues
// filled when the stimulus is driven; command/ack timing is checked inline per cycle.
module tb_bmem_arbiter;
  import rv32i_types::*;

  localparam int BL = 4;
  localparam int BW = 64;
  localparam int AW = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           i_req_read, i_req_ack, i_flush, i_rvalid;
  logic [AW-1:0]  i_req_addr, i_raddr;
  logic [BW-1:0]  i_rdata;
  logic           d_req_read, d_req_write, d_req_ack, d_rvalid;
  logic [AW-1:0]  d_req_addr, d_raddr;
  logic [BL*BW-1:0] d_req_wdata;
  logic [BW-1:0]  d_rdata;
  logic [AW-1:0]  bmem_addr, bmem_raddr;
  logic           bmem_read, bmem_write, bmem_ready, bmem_rvalid;
  logic [BW-1:0]  bmem_wdata, bmem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  logic [BW-1:0] exp_i_data[$];
  logic [AW-1:0] exp_i_addr[$];
  logic [BW-1:0] exp_d_data[$];
  logic [AW-1:0] exp_d_addr[$];
  logic [BW-1:0] exp_wdata[$];

  bmem_arbiter #(.BURST_LEN(BL), .BEAT_W(BW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .i_req_read(i_req_read), .i_req_addr(i_req_addr), .i_req_ack(i_req_ack),
    .i_flush(i_flush), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_raddr(i_raddr),
    .d_req_read(d_req_read), .d_req_write(d_req_write), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_ack(d_req_ack), .d_rdata(d_rdata),
    .d_rvalid(d_rvalid), .d_raddr(d_raddr),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] beat_val(input logic [AW-1:0] a, input int k);
    logic [31:0] kk;
    kk = k;
    return {a, 24'h5a3c00, kk[7:0]};
  endfunction

  // Scoreboard pass for the current (settled) cycle, then advance to just after the next edge.
  task automatic step();
    logic [BW-1:0] ed;
    logic [AW-1:0] ea;
    if (i_rvalid === 1'b1) begin
      n_cmp++;
      if (exp_i_data.size() == 0) begin
        n_err++;
        $display("FAIL i_beat_unexpected: got data=%h addr=%h, required no beat", i_rdata, i_raddr);
      end else begin
        ed = exp_i_data.pop_front();
        ea = exp_i_addr.pop_front();
        if (i_rdata !== ed || i_raddr !== ea) begin
          n_err++;
          $display("FAIL i_beat: got data=%h addr=%h, required data=%h addr=%h", i_rdata, i_raddr, ed, ea);
        end
      end
    end
    if (d_rvalid === 1'b1) begin
      n_cmp++;
      if (exp_d_data.size() == 0) begin
        n_err++;
        $display("FAIL d_beat_unexpected: got data=%h addr=%h, required no beat", d_rdata, d_raddr);
      end else begin
        ed = exp_d_data.pop_front();
        ea = exp_d_addr.pop_front();
        if (d_rdata !== ed || d_raddr !== ea) begin
          n_err++;
          $display("FAIL d_beat: got data=%h addr=%h, required data=%h addr=%h", d_rdata, d_raddr, ed, ea);
        end
      end
    end
    if (bmem_write === 1'b1 && bmem_ready === 1'b1) begin
      n_cmp++;
      if (exp_wdata.size() == 0) begin
        n_err++;
        $display("FAIL wbeat_unexpected: got wdata=%h, required no write", bmem_wdata);
      end else begin
        ed = exp_wdata.pop_front();
        if (bmem_wdata !== ed) begin
          n_err++;
          $display("FAIL wbeat: got wdata=%h, required %h", bmem_wdata, ed);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // dest: 0 = beat must be swallowed, 1 = instruction side, 2 = data side
  task automatic send_beat(input logic [AW-1:0] a, input int k, input int dest);
    bmem_rvalid = 1'b1;
    bmem_raddr  = a;
    bmem_rdata  = beat_val(a, k);
    if (dest == 1) begin exp_i_data.push_back(beat_val(a, k)); exp_i_addr.push_back(a); end
    if (dest == 2) begin exp_d_data.push_back(beat_val(a, k)); exp_d_addr.push_back(a); end
    #1;
    step();
    bmem_rvalid = 1'b0;
    bmem_raddr  = '0;
    bmem_rdata  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_req_read = 0; i_req_addr = '0; i_flush = 0;
    d_req_read = 0; d_req_write = 0; d_req_addr = '0; d_req_wdata = '0;
    bmem_ready = 1; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 0;
    #1; step();
    #1; step();
    #1;
    n_cmp++;
    if ({i_req_ack, d_req_ack, bmem_read, bmem_write, i_rvalid, d_rvalid} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_strobes: got %b, required 000000",
               {i_req_ack, d_req_ack, bmem_read, bmem_write, i_rvalid, d_rvalid});
    end
    n_cmp++;
    if (bmem_addr !== '0 || bmem_wdata !== '0) begin
      n_err++;
      $display("FAIL reset_bus: got addr=%h wdata=%h, required 0/0", bmem_addr, bmem_wdata);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({bmem_read, bmem_write, bmem_addr} !== {2'b00, 32'h0}) begin
      n_err++;
      $display("FAIL idle_after_reset: got rd=%b wr=%b addr=%h, required 0 0 0", bmem_read, bmem_write, bmem_addr);
    end
    step();
  endtask

  task automatic test_single_read();
    logic [AW-1:0] a = 32'h1eceb000;
    i_req_read = 1; i_req_addr = a;
    #1;
    n_cmp++;
    if (bmem_read !== 1'b0) begin n_err++; $display("FAIL i_cmd_latency: got bmem_read=%b, required 0", bmem_read); end
    step();
    #1;
    n_cmp++;
    if ({bmem_read, i_req_ack, d_req_ack} !== 3'b110 || bmem_addr !== a) begin
      n_err++;
      $display("FAIL i_cmd: got rd/iack/dack=%b addr=%h, required 110 addr=%h", {bmem_read, i_req_ack, d_req_ack}, bmem_addr, a);
    end
    step();
    i_req_read = 0;
    #1;
    n_cmp++;
    if (bmem_read !== 1'b0 || i_req_ack !== 1'b0) begin
      n_err++;
      $display("FAIL i_cmd_one_cycle: got rd=%b iack=%b, required 0 0", bmem_read, i_req_ack);
    end
    for (int k = 0; k < BL; k++) send_beat(a, k, 1);
    n_cmp++;
    if (exp_i_data.size() != 0) begin n_err++; $display("FAIL single_read_drain: got %0d beats left, required 0", exp_i_data.size()); end
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] ai0 = 32'h1eceb000, ad0 = 32'h1eceb040;
    logic [AW-1:0] ai1 = 32'h2000_0100, ad1 = 32'h2000_0200;
    i_req_read = 1; i_req_addr = ai0; d_req_read = 1; d_req_addr = ad0;
    #1; step();
    #1;
    n_cmp++;
    if (bmem_addr !== ad0 || {bmem_read, d_req_ack, i_req_ack} !== 3'b110) begin
      n_err++;
      $display("FAIL rr_first_d: got addr=%h rd/dack/iack=%b, required addr=%h 110", bmem_addr, {bmem_read, d_req_ack, i_req_ack}, ad0);
    end
    step();
    d_req_read = 0;
    for (int k = 0; k < BL; k++) send_beat(ad0, k, 2);
    #1;
    n_cmp++;
    if (bmem_read !== 1'b0) begin n_err++; $display("FAIL rr_i_waits_idle: got bmem_read=%b, required 0", bmem_read); end
    step();
    #1;
    n_cmp++;
    if (bmem_addr !== ai0 || i_req_ack !== 1'b1) begin
      n_err++;
      $display("FAIL rr_then_i: got addr=%h iack=%b, required addr=%h iack=1", bmem_addr, i_req_ack, ai0);
    end
    step();
    i_req_read = 0;
    for (int k = 0; k < BL; k++) send_beat(ai0, k, 1);
    i_req_read = 1; i_req_addr = ai1; d_req_read = 1; d_req_addr = ad1;
    #1; step();
    #1;
    n_cmp++;
    if (bmem_addr !== ai1 || {i_req_ack, d_req_ack} !== 2'b10) begin
      n_err++;
      $display("FAIL rr_second_i: got addr=%h iack/dack=%b, required addr=%h 10", bmem_addr, {i_req_ack, d_req_ack}, ai1);
    end
    step();
    i_req_read = 0;
    for (int k = 0; k < BL; k++) send_beat(ai1, k, 1);
    #1; step();
    #1;
    n_cmp++;
    if (bmem_addr !== ad1 || d_req_ack !== 1'b1) begin
      n_err++;
      $display("FAIL rr_second_d: got addr=%h dack=%b, required addr=%h dack=1", bmem_addr, d_req_ack, ad1);
    end
    step();
    d_req_read = 0;
    for (int k = 0; k < BL; k++) send_beat(ad1, k, 2);
    n_cmp++;
    if (exp_i_data.size() + exp_d_data.size() != 0) begin
      n_err++;
      $display("FAIL rr_drain: got %0d beats left, required 0", exp_i_data.size() + exp_d_data.size());
    end
  endtask

  task automatic test_write_backpressure();
    logic [AW-1:0] a = 32'h1eceb020;
    logic [BW-1:0] wb [BL];
    int  idx_t [7] = '{0, 1, 2, 2, 2, 2, 3};
    bit  rdy_t [7] = '{1, 1, 0, 0, 0, 1, 1};
    bit  ack_t [7] = '{0, 0, 0, 0, 0, 0, 1};
    wb[0] = 64'haaaa_0000_1111_0001;
    wb[1] = 64'hbbbb_0000_2222_0002;
    wb[2] = 64'hcccc_0000_3333_0003;
    wb[3] = 64'hdddd_0000_4444_0004;
    for (int k = 0; k < BL; k++) exp_wdata.push_back(wb[k]);
    d_req_write = 1; d_req_addr = a; d_req_wdata = {wb[3], wb[2], wb[1], wb[0]};
    #1; step();
    for (int c = 0; c < 7; c++) begin
      bmem_ready = rdy_t[c];
      #1;
      n_cmp++;
      if (bmem_write !== 1'b1 || bmem_addr !== a || bmem_wdata !== wb[idx_t[c]] || d_req_ack !== ack_t[c]) begin
        n_err++;
        $display("FAIL wr_cycle%0d: got wr=%b addr=%h wdata=%h dack=%b, required 1 %h %h %b",
                 c, bmem_write, bmem_addr, bmem_wdata, d_req_ack, a, wb[idx_t[c]], ack_t[c]);
      end
      step();
    end
    d_req_write = 0;
    bmem_ready  = 1;
    #1;
    n_cmp++;
    if (bmem_write !== 1'b0 || d_req_ack !== 1'b0 || exp_wdata.size() != 0) begin
      n_err++;
      $display("FAIL wr_done: got wr=%b dack=%b left=%0d, required 0 0 0", bmem_write, d_req_ack, exp_wdata.size());
    end
    step();
  endtask

  task automatic test_flush();
    logic [AW-1:0] ai = 32'h1eceb000, ad0 = 32'h3000_0040, ad1 = 32'h3000_0060;
    i_req_read = 1; i_req_addr = ai; bmem_ready = 0;
    #1; step();
    #1;
    n_cmp++;
    if (bmem_read !== 1'b1 || i_req_ack !== 1'b0) begin
      n_err++;
      $display("FAIL flush_pre_stall: got rd=%b iack=%b, required 1 0", bmem_read, i_req_ack);
    end
    step();
    i_flush = 1; i_req_read = 0; d_req_read = 1; d_req_addr = ad0;
    #1;
    n_cmp++;
    if (i_req_ack !== 1'b0) begin n_err++; $display("FAIL flush_pre_noack: got iack=%b, required 0", i_req_ack); end
    step();
    i_flush = 0; bmem_ready = 1;
    #1;
    n_cmp++;
    if (bmem_read !== 1'b0) begin n_err++; $display("FAIL flush_pre_idle: got bmem_read=%b, required 0", bmem_read); end
    step();
    #1;
    n_cmp++;
    if (bmem_addr !== ad0 || d_req_ack !== 1'b1) begin
      n_err++;
      $display("FAIL flush_pre_then_d: got addr=%h dack=%b, required %h 1", bmem_addr, d_req_ack, ad0);
    end
    step();
    d_req_read = 0;
    for (int k = 0; k < BL; k++) send_beat(ad0, k, 2);

    i_req_read = 1; i_req_addr = ai;
    #1; step();
    #1;
    n_cmp++;
    if (i_req_ack !== 1'b1) begin n_err++; $display("FAIL flush_inflight_ack: got iack=%b, required 1", i_req_ack); end
    step();
    i_req_read = 0; d_req_read = 1; d_req_addr = ad1;
    send_beat(ai, 0, 1);
    i_flush = 1;
    bmem_rvalid = 1; bmem_raddr = ai; bmem_rdata = beat_val(ai, 1);
    #1;
    n_cmp++;
    if (i_rvalid !== 1'b0) begin n_err++; $display("FAIL flush_cycle_beat: got i_rvalid=%b, required 0", i_rvalid); end
    step();
    i_flush = 0; bmem_rvalid = 0;
    send_beat(ai, 2, 0);
    send_beat(ai, 3, 0);
    #1;
    n_cmp++;
    if (bmem_read !== 1'b0) begin n_err++; $display("FAIL flush_drain_idle: got bmem_read=%b, required 0", bmem_read); end
    step();
    #1;
    n_cmp++;
    if (bmem_addr !== ad1 || d_req_ack !== 1'b1) begin
      n_err++;
      $display("FAIL flush_then_d: got addr=%h dack=%b, required %h 1", bmem_addr, d_req_ack, ad1);
    end
    step();
    d_req_read = 0;
    for (int k = 0; k < BL; k++) send_beat(ad1, k, 2);
    n_cmp++;
    if (exp_i_data.size() + exp_d_data.size() != 0) begin
      n_err++;
      $display("FAIL flush_drain: got %0d beats left, required 0", exp_i_data.size() + exp_d_data.size());
    end
  endtask

  task automatic test_stray_beat();
    logic [AW-1:0] a = 32'h4000_0080;
    d_req_read = 1; d_req_addr = a;
    #1; step();
    #1;
    n_cmp++;
    if (d_req_ack !== 1'b1) begin n_err++; $display("FAIL stray_ack: got dack=%b, required 1", d_req_ack); end
    step();
    d_req_read = 0;
    send_beat(a, 0, 2);
    bmem_rvalid = 1; bmem_raddr = 32'h0; bmem_rdata = 64'hdead_beef_dead_beef;
    #1;
    n_cmp++;
    if (d_rvalid !== 1'b0) begin n_err++; $display("FAIL stray_ignored: got d_rvalid=%b, required 0", d_rvalid); end
    step();
    bmem_rvalid = 0;
    for (int k = 1; k < BL; k++) send_beat(a, k, 2);
    n_cmp++;
    if (exp_d_data.size() != 0) begin n_err++; $display("FAIL stray_count: got %0d beats left, required 0", exp_d_data.size()); end
  endtask

  task automatic test_reset_mid_burst();
    logic [AW-1:0] ai = 32'h5000_0020, ad = 32'h5000_0140;
    i_req_read = 1; i_req_addr = ai;
    #1; step();
    #1; step();
    i_req_read = 0;
    send_beat(ai, 0, 1);
    send_beat(ai, 1, 1);
    rst = 1;
    #1; step();
    rst = 0;
    #1;
    n_cmp++;
    if ({i_req_ack, d_req_ack, bmem_read, bmem_write, i_rvalid, d_rvalid} !== 6'b0 || bmem_addr !== '0) begin
      n_err++;
      $display("FAIL rst_mid_burst: got strobes=%b addr=%h, required 000000 0",
               {i_req_ack, d_req_ack, bmem_read, bmem_write, i_rvalid, d_rvalid}, bmem_addr);
    end
    bmem_rvalid = 1; bmem_raddr = ai; bmem_rdata = beat_val(ai, 2);
    #1;
    n_cmp++;
    if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL idle_beat_dropped: got i/d rvalid=%b%b, required 00", i_rvalid, d_rvalid);
    end
    step();
    bmem_rvalid = 0;
    d_req_read = 1; d_req_addr = ad;
    #1; step();
    #1;
    n_cmp++;
    if (bmem_addr !== ad || {bmem_read, d_req_ack} !== 2'b11) begin
      n_err++;
      $display("FAIL rst_then_d: got addr=%h rd/dack=%b, required %h 11", bmem_addr, {bmem_read, d_req_ack}, ad);
    end
    step();
    d_req_read = 0;
    for (int k = 0; k < BL; k++) send_beat(ad, k, 2);
    n_cmp++;
    if (exp_i_data.size() + exp_d_data.size() != 0) begin
      n_err++;
      $display("FAIL rst_drain: got %0d beats left, required 0", exp_i_data.size() + exp_d_data.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_backpressure();
    test_flush();
    test_stray_beat();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
